// File: rtl/jk_excitation_counter_if.sv
// ----------------------------------------------------------------------------
// jk_excitation_counter_if
//   Request/status bundle for jk_excitation_counter.
//   master : drives enable/up/load/load_value, observes count and excitations
//   slave  : the counter itself
//   Signals:
//     enable, up, load, load_value  - step / direction / synchronous load
//     count                         - registered state
//     j_out, k_out                  - toggle-form JK excitations (combinational)
//     tc, wrap, load_err            - terminal count, wrap pulse, bad-load pulse
//     count_gray, gray_j            - only when JK_GRAY_OUT_EN is defined
// ----------------------------------------------------------------------------
interface jk_excitation_counter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             enable;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] j_out;
   logic [WIDTH-1:0] k_out;
   logic             tc;
   logic             wrap;
   logic             load_err;
`ifdef JK_GRAY_OUT_EN
   logic [WIDTH-1:0] count_gray;
   logic [WIDTH-1:0] gray_j;
`endif

   modport master (
      output enable, up, load, load_value,
      input  count, j_out, k_out, tc, wrap, load_err
`ifdef JK_GRAY_OUT_EN
      , input count_gray, gray_j
`endif
   );

   modport slave (
      input  enable, up, load, load_value,
      output count, j_out, k_out, tc, wrap, load_err
`ifdef JK_GRAY_OUT_EN
      , output count_gray, gray_j
`endif
   );
endinterface

// File: rtl/jk_excitation_counter.sv
// ----------------------------------------------------------------------------
// jk_excitation_counter
//   Modulo-MODULO up/down counter whose state bits are only ever updated via
//   J/K excitations computed here from (current state, desired next state).
//   The excitations are exported so an external JK bank can run in lockstep.
//   Ports:
//     clock  - rising-edge clock
//     clear  - asynchronous active-low reset
//     bus    - jk_excitation_counter_if.slave (requests, count, j/k, tc,
//              wrap, load_err)
//   Parameters: WIDTH (state bits), MODULO (2 <= MODULO <= 2**WIDTH)
//   Optional: define JK_GRAY_OUT_EN to add bus.count_gray and bus.gray_j.
// ----------------------------------------------------------------------------
module jk_excitation_counter #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned MODULO = 10
) (
   input  logic                   clock,
   input  logic                   clear,
   jk_excitation_counter_if.slave bus
);

   if (MODULO < 2 || 64'(MODULO) > (64'd1 << WIDTH)) begin : g_bad_modulo
      $error("jk_excitation_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
   end

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULO - 1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] next_count;
   logic [WIDTH-1:0] j_c;
   logic [WIDTH-1:0] k_c;
   logic             tc_c;
   logic             load_oob;
   logic             wrap_q;
   logic             load_err_q;

   // Next-state selection: load > enable > hold.
   always_comb begin
      load_oob   = bus.load && (32'(bus.load_value) >= MODULO);
      tc_c       = bus.enable && !bus.load &&
                   ((bus.up && count_q == LAST) || (!bus.up && count_q == '0));
      next_count = count_q;
      if (bus.load) begin
         next_count = load_oob ? '0 : bus.load_value;
      end else if (bus.enable) begin
         if (bus.up) next_count = (count_q == LAST) ? '0 : count_q + 1'b1;
         else        next_count = (count_q == '0) ? LAST : count_q - 1'b1;
      end
   end

   // Toggle-form excitation: J=K=1 where the bit changes, 00 elsewhere.
   // Forced to 0 while clear is asserted so the external bank sees no activity.
   always_comb begin
      j_c = clear ? (count_q ^ next_count) : '0;
      k_c = j_c;
   end

   // Each bit follows the JK characteristic Q+ = J&~Q | ~K&Q.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         count_q    <= '0;
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            count_q[i] <= (j_c[i] & ~count_q[i]) | (~k_c[i] & count_q[i]);
         end
         wrap_q     <= tc_c;
         load_err_q <= load_oob;
      end
   end

   assign bus.count    = count_q;
   assign bus.j_out    = j_c;
   assign bus.k_out    = k_c;
   assign bus.tc       = tc_c;
   assign bus.wrap     = wrap_q;
   assign bus.load_err = load_err_q;

`ifdef JK_GRAY_OUT_EN
   logic [WIDTH-1:0] gray_c;
   logic [WIDTH-1:0] gray_next;

   always_comb begin
      gray_c    = count_q ^ (count_q >> 1);
      gray_next = next_count ^ (next_count >> 1);
   end

   assign bus.count_gray = gray_c;
   assign bus.gray_j     = clear ? (gray_c ^ gray_next) : '0;
`endif

endmodule

// File: tb/tb_jk_excitation_counter.sv
module tb_jk_excitation_counter;

   localparam int unsigned W = 4;
`ifdef JK_GRAY_OUT_EN
   localparam int unsigned MOD = 16;
`else
   localparam int unsigned MOD = 10;
`endif

   typedef struct {
      logic [W-1:0] count;
      logic         wrap;
      logic         load_err;
   } exp_t;

   logic clock = 1'b0;
   logic clear = 1'b0;
   always #5 clock = ~clock;

   jk_excitation_counter_if #(.WIDTH(W)) bus ();

   jk_excitation_counter #(.WIDTH(W), .MODULO(MOD)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   exp_t         sb[$];
   int           n_cmp = 0;
   int           n_err = 0;
   int unsigned  m_count = 0;
   logic         exp_tc;
   logic [W-1:0] exp_mask;
   logic [W-1:0] exp_gray_j;

   function automatic int unsigned model_next(int unsigned c, bit en, bit u, bit ld,
                                              int unsigned lv);
      if (ld) return (lv < MOD) ? lv : 0;
      if (en) return u ? (c + 1) % MOD : (c + MOD - 1) % MOD;
      return c;
   endfunction

   function automatic logic [W-1:0] gray(int unsigned v);
      logic [W-1:0] b;
      b = W'(v);
      return b ^ (b >> 1);
   endfunction

   // Drive one request, predict its outcome and queue the post-edge expectation.
   task automatic apply(input bit en, input bit u, input bit ld, input int unsigned lv);
      exp_t        e;
      int unsigned nxt;
      bus.enable     = en;
      bus.up         = u;
      bus.load       = ld;
      bus.load_value = W'(lv);
      nxt        = model_next(m_count, en, u, ld, lv);
      exp_tc     = en && !ld && (u ? (m_count == MOD - 1) : (m_count == 0));
      exp_mask   = W'(m_count) ^ W'(nxt);
      exp_gray_j = gray(m_count) ^ gray(nxt);
      e.count    = W'(nxt);
      e.wrap     = exp_tc;
      e.load_err = ld && (lv >= MOD);
      sb.push_back(e);
      m_count = nxt;
      #1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      bus.enable = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.load_value = '0;
      clear = 1'b0;
      repeat (2) @(posedge clock);
      #3;
      n_cmp++;
      if (bus.count !== '0 || bus.wrap !== 1'b0 || bus.load_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_init: count=%0d wrap=%b load_err=%b, expected 0/0/0",
                  bus.count, bus.wrap, bus.load_err);
      end
      clear = 1'b1;
      m_count = 0;
      tick();
      // Reach count=7 then assert clear between edges.
      apply(0, 1, 1, 7);
      tick();
      n_cmp++;
      if (sb.size() == 0) begin
         n_err++; $display("FAIL reset_load7: scoreboard empty");
      end else begin
         e = sb.pop_front();
         if (bus.count !== e.count) begin
            n_err++; $display("FAIL reset_load7: count=%0d expected %0d", bus.count, e.count);
         end
      end
      bus.load = 1'b0; bus.enable = 1'b1;
      #2 clear = 1'b0;
      #1;
      n_cmp++;
      if (bus.count !== '0 || bus.wrap !== 1'b0 || bus.load_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_async: count=%0d wrap=%b load_err=%b, expected 0/0/0",
                  bus.count, bus.wrap, bus.load_err);
      end
      n_cmp++;
      if (bus.j_out !== '0 || bus.k_out !== '0) begin
         n_err++; $display("FAIL reset_jk: j=%b k=%b expected 0000/0000", bus.j_out, bus.k_out);
      end
      @(posedge clock);
      #1;
      n_cmp++;
      if (bus.count !== '0) begin
         n_err++; $display("FAIL reset_hold: count=%0d expected 0", bus.count);
      end
      #2 clear = 1'b1;
      bus.enable = 1'b0;
      m_count = 0;
      tick();
   endtask

   task automatic test_up_wrap();
      exp_t e;
      for (int i = 0; i < 10; i++) begin
         apply(1, 1, 0, 0);
         n_cmp++;
         if (bus.tc !== exp_tc || bus.j_out !== exp_mask) begin
            n_err++;
            $display("FAIL up_comb[%0d]: tc=%b j=%b expected tc=%b j=%b",
                     i, bus.tc, bus.j_out, exp_tc, exp_mask);
         end
         tick();
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++; $display("FAIL up_state[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if (bus.count !== e.count || bus.wrap !== e.wrap || bus.load_err !== e.load_err) begin
               n_err++;
               $display("FAIL up_state[%0d]: count=%0d wrap=%b lerr=%b expected %0d/%b/%b",
                        i, bus.count, bus.wrap, bus.load_err, e.count, e.wrap, e.load_err);
            end
         end
      end
   endtask

   task automatic test_down_wrap();
      exp_t e;
      for (int i = 0; i < 10; i++) begin
         apply(1, 0, 0, 0);
         if (i == 0) begin
            n_cmp++;
            if (bus.j_out !== W'(MOD - 1) || bus.k_out !== W'(MOD - 1)) begin
               n_err++;
               $display("FAIL down_mask0: j=%b k=%b expected %b", bus.j_out, bus.k_out, W'(MOD - 1));
            end
         end
         n_cmp++;
         if (bus.tc !== exp_tc || bus.j_out !== exp_mask) begin
            n_err++;
            $display("FAIL down_comb[%0d]: tc=%b j=%b expected tc=%b j=%b",
                     i, bus.tc, bus.j_out, exp_tc, exp_mask);
         end
         tick();
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++; $display("FAIL down_state[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if (bus.count !== e.count || bus.wrap !== e.wrap || bus.load_err !== e.load_err) begin
               n_err++;
               $display("FAIL down_state[%0d]: count=%0d wrap=%b lerr=%b expected %0d/%b/%b",
                        i, bus.count, bus.wrap, bus.load_err, e.count, e.wrap, e.load_err);
            end
         end
      end
   endtask

   task automatic test_loads();
      exp_t        e;
      bit          t_en[9] = '{1, 1, 1, 0, 1, 0, 0, 0, 0};
      bit          t_ld[9] = '{1, 1, 1, 1, 0, 1, 0, 1, 0};
      int unsigned t_lv[9] = '{6, MOD - 1, 3, MOD - 1, 0, 12, 0, MOD % 16, 0};
      for (int i = 0; i < 9; i++) begin
         apply(t_en[i], 1, t_ld[i], t_lv[i]);
         n_cmp++;
         if (bus.tc !== exp_tc || bus.j_out !== exp_mask) begin
            n_err++;
            $display("FAIL load_comb[%0d]: tc=%b j=%b expected tc=%b j=%b",
                     i, bus.tc, bus.j_out, exp_tc, exp_mask);
         end
         tick();
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++; $display("FAIL load_state[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if (bus.count !== e.count || bus.wrap !== e.wrap || bus.load_err !== e.load_err) begin
               n_err++;
               $display("FAIL load_state[%0d]: count=%0d wrap=%b lerr=%b expected %0d/%b/%b",
                        i, bus.count, bus.wrap, bus.load_err, e.count, e.wrap, e.load_err);
            end
         end
      end
   endtask

   task automatic test_cross_check();
      exp_t         e;
      logic [W-1:0] ext;
      logic [W-1:0] js;
      logic [W-1:0] ks;
      ext = W'(m_count);
      for (int i = 0; i < 200; i++) begin
         apply($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
               $urandom_range(0, 15));
         js = bus.j_out;
         ks = bus.k_out;
         n_cmp++;
         if (js !== ks || js !== exp_mask) begin
            n_err++;
            $display("FAIL xchk_jk[%0d]: j=%b k=%b expected both %b", i, js, ks, exp_mask);
         end
         tick();
         for (int b = 0; b < W; b++) begin
            case ({js[b], ks[b]})
               2'b01:   ext[b] = 1'b0;
               2'b10:   ext[b] = 1'b1;
               2'b11:   ext[b] = ~ext[b];
               default: ext[b] = ext[b];
            endcase
         end
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++; $display("FAIL xchk_state[%0d]: scoreboard empty", i);
         end else begin
            e = sb.pop_front();
            if (bus.count !== ext || bus.count !== e.count || bus.wrap !== e.wrap ||
                bus.load_err !== e.load_err) begin
               n_err++;
               $display("FAIL xchk_state[%0d]: count=%0d ext=%0d wrap=%b lerr=%b expected %0d/%b/%b",
                        i, bus.count, ext, bus.wrap, bus.load_err, e.count, e.wrap, e.load_err);
            end
         end
      end
   endtask

`ifdef JK_GRAY_OUT_EN
   task automatic test_gray();
      exp_t         e;
      logic [W-1:0] prev_g;
      prev_g = bus.count_gray;
      for (int i = 0; i < 2 * MOD + 4; i++) begin
         apply(1, (i < 2 * MOD), 0, 0);
         n_cmp++;
         if (bus.gray_j !== exp_gray_j) begin
            n_err++; $display("FAIL gray_j[%0d]: got %b expected %b", i, bus.gray_j, exp_gray_j);
         end
         tick();
         if (sb.size() != 0) e = sb.pop_front();
         n_cmp++;
         if (bus.count_gray !== gray(m_count) || $countones(bus.count_gray ^ prev_g) != 1) begin
            n_err++;
            $display("FAIL gray_step[%0d]: got %b prev %b expected %b",
                     i, bus.count_gray, prev_g, gray(m_count));
         end
         prev_g = bus.count_gray;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_loads();
      test_cross_check();
`ifdef JK_GRAY_OUT_EN
      test_gray();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/jk_excitation_counter.md
Name: jk_excitation_counter

Overview:
- Modulo-N up/down counter whose state is held as a bank of JK-style bits.
- Each bit is updated only through J/K excitations that the block computes from current state and desired next state.
- It is the driving side of the JK flip-flop interface: it generates the J/K pairs rather than consuming them.
- The excitations are exported so an external bank of JK flops can be run in lockstep and cross-checked.

Parameters:
- WIDTH, 4: number of state bits.
- MODULO, 10: count range 0..MODULO-1. Requires 2 <= MODULO <= 2**WIDTH; elaboration-time $error otherwise.

Ports:
- clock, input, 1: rising-edge clock.
- clear, input, 1: asynchronous, active-low reset.
- enable, input, 1: advance count this cycle.
- up, input, 1: 1 = increment, 0 = decrement.
- load, input, 1: synchronous load request.
- load_value, input, WIDTH: value to load.
- count, output, WIDTH: current state (registered).
- j_out, output, WIDTH: J excitation applied at the next rising edge (combinational).
- k_out, output, WIDTH: K excitation applied at the next rising edge (combinational).
- tc, output, 1: terminal count (combinational).
- wrap, output, 1: registered one-cycle pulse after a wrap.
- load_err, output, 1: registered one-cycle pulse after an out-of-range load.

Behaviour:
- Reset: clear=0 asynchronously forces count=0, wrap=0, load_err=0. While clear=0, j_out and k_out are all 0. Reset mid-count aborts immediately; the first edge after clear rises applies normal rules from count=0.
- Next-state selection, priority load > enable > hold:
  - load=1 and load_value < MODULO: next = load_value.
  - load=1 and load_value >= MODULO: next = 0, and load_err=1 for one cycle after the edge.
  - enable=1, up=1: next = count+1, or 0 if count == MODULO-1.
  - enable=1, up=0: next = count-1, or MODULO-1 if count == 0.
  - Otherwise: next = count.
- Excitation, toggle-form, per bit: j_out[i] = k_out[i] = count[i] XOR next[i].
  - Hold is encoded as J=K=0; change is encoded as J=K=1.
  - The 01 and 10 codes are never produced.
- State update: each bit obeys JK semantics on its own excitation (00 hold, 01 reset, 10 set, 11 toggle). As a result, count equals next after the edge.
- Latency: count reflects a request one edge after it is sampled. j_out and k_out reflect same-cycle inputs.
- tc = enable AND NOT load AND ((up AND count == MODULO-1) OR (NOT up AND count == 0)).
- wrap: registered tc, so it is high for exactly the cycle after the wrapping edge. A load never sets wrap.
- Direction change takes effect on the same edge. There is no hysteresis.
- Simultaneous load and enable: load wins, no wrap pulse.
- Out-of-range state is unreachable (every load is range-checked). When MODULO == 2**WIDTH, wrap is natural overflow and underflow.

Optional Feature:
- Macro: JK_GRAY_OUT_EN.
- Defined:
  - Adds output count_gray, width WIDTH, equal to count XOR (count >> 1). It is combinational from the registered count, so no added latency.
  - Adds output gray_j, width WIDTH: toggle-form excitation for a Gray-coded external bank, equal to count_gray XOR gray(next). It is 0 during reset.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Reset → count, wrap and load_err:
  - clear=0 mid-count at count=7 → count=0 asynchronously, before the next clock edge.
  - wrap=0 and load_err=0.
- Up count to wrap:
  - clear=1, enable=1, up=1 for 10 edges → count 1,2,...,9,0.
  - tc=1 only while count=9; wrap=1 only in the cycle count=0.
- Down count to wrap:
  - From 0 with up=0 → count 9,8,...
  - At count=0, j_out = k_out = 4'b1001, matching the 0→9 toggle mask. wrap pulses after the 0→9 edge.
- Loads:
  - load=1, load_value=6 with enable=1 → count=6, no wrap.
  - load_value=12 → count=0 and load_err=1 for exactly one cycle.
- Excitation cross-check: an external JK model driven by j_out and k_out for 200 random enable/up/load cycles → its state always equals count. j_out never differs from k_out.
- With JK_GRAY_OUT_EN defined, MODULO=16: count_gray changes by exactly one bit per enabled step, including the 15→0 wrap.
